detecter_1011: RTL and testbench
================================

DETECTER_1011 -- requirements
Module: detecter_1011

Interface
REQ-001 Parameter OVERLAP, default 1, meaning: 1 = overlapping detection (a match's trailing bits may start the next match), 0 = non-overlapping.
REQ-002 Parameter CNT_W, default 8, meaning: width of the match counter.
REQ-003 Port clk  input  1  single system clock, all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port in  input  1  serial bit stream, sampled once per rising clk edge.
REQ-006 Port out  output  1  match flag: high for exactly one cycle after the 4th bit of "1011" is sampled.
REQ-007 Port match_count  output  CNT_W  number of matches since reset, saturating.
REQ-008 Port declaration order SHALL be in, out, clk, rst_n, match_count, so that 3-port positional instantiations (in, out, clk) remain valid.

Function
REQ-009 The block SHALL be a Moore FSM: out SHALL be decoded from the registered state only, never combinationally from in.
REQ-010 States SHALL be S_IDLE (no prefix), S_1 ("1"), S_10 ("10"), S_101 ("101") and S_1011 (match).
REQ-011 Transitions, written as state: in=0 -> / in=1 ->, SHALL be S_IDLE: S_IDLE / S_1; S_1: S_10 / S_1; S_10: S_IDLE / S_101; S_101: S_10 / S_1011.
REQ-012 With OVERLAP=1, S_1011 SHALL go to S_10 on in=0 and to S_1 on in=1.
REQ-013 With OVERLAP=0, S_1011 SHALL go to S_IDLE on in=0 and to S_1 on in=1.
REQ-014 out SHALL be 1 only in S_1011, so latency is one clock from the edge that samples the final "1" to out high.
REQ-015 Back-to-back matches SHALL each produce a separate one-cycle out pulse.
REQ-016 match_count SHALL increment by 1 on each edge that enters S_1011.
REQ-017 match_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-018 An X or Z value on in SHALL NOT be required to give defined behaviour; benches SHALL drive in to 0 or 1 whenever rst_n is high.
REQ-019 Illegal state encodings SHALL return to S_IDLE on the next edge, with out=0.

Reset
REQ-020 When rst_n goes low, state SHALL go to S_IDLE, out to 0 and match_count to 0 immediately, without waiting for a clock edge.
REQ-021 While rst_n is low, in SHALL be ignored.
REQ-022 Reset asserted mid-sequence, including in S_1011, SHALL discard the partial match.
REQ-023 After rst_n is released, the first rising edge SHALL sample in from S_IDLE.

Structure
REQ-024 State encoding constants (a state typedef or localparams) SHALL live in a shared package, detecter_pkg, together with the pattern constant 4'b1011.
REQ-025 The block SHALL consist of one state register, next-state logic, output decode and a counter.
REQ-026 The saturating counter MAY be a sub-module named sat_counter; no other sub-module is warranted.

Verification
REQ-027 Stimulus: reset, then in = 1,0,1,0,1,1,1,1,0,1,1,0,1,1 on consecutive edges, OVERLAP=1 -> out high in exactly the cycles after bits 6, 11 and 14; match_count = 3.
REQ-028 Stimulus: same sequence with OVERLAP=0 -> out high only after bits 6 and 11; match_count = 2.
REQ-029 Stimulus: 1,0,1,1,0,1,1 with OVERLAP=1 -> two separate one-cycle pulses (after bits 4 and 7).
REQ-030 Stimulus: rst_n pulsed low between clock edges while in S_101 -> out=0 and match_count=0 immediately; a following "1" does not match.
REQ-031 Stimulus: CNT_W=2 with 5 matches -> match_count holds at 3.
REQ-032 Stimulus: all-ones or all-zeros input for 20 cycles -> out stays 0.

Source files
------------

// File: rtl/detecter_pkg.sv
// ---------------------------------------------------------------------------
// detecter_pkg
// Shared definitions for the "1011" serial sequence detector.
//   state_t     : FSM state encoding (prefix of the pattern seen so far)
//   PATTERN     : the bit pattern being searched for, oldest bit first
//   next_state  : transition function shared by the detector FSM
// ---------------------------------------------------------------------------
package detecter_pkg;

    localparam logic [3:0] PATTERN = 4'b1011;

    // Each state names the longest pattern prefix that ends at the latest bit.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3,
        S_1011 = 3'd4
    } state_t;

    // Advance the prefix tracker by one input bit. On a mismatch the state
    // falls back to the longest suffix that is still a prefix of PATTERN.
    // After a full match, overlap keeps the trailing "1"/"10" alive, while
    // non-overlapping mode only lets a fresh leading "1" restart the search.
    // Unused encodings recover to S_IDLE.
    function automatic state_t next_state(input state_t cur, input logic b,
                                          input logic overlap);
        state_t nxt;
        nxt = S_IDLE;
        case (cur)
            S_IDLE:  nxt = (b == PATTERN[3]) ? S_1    : S_IDLE;
            S_1:     nxt = (b == PATTERN[2]) ? S_10   : S_1;
            S_10:    nxt = (b == PATTERN[1]) ? S_101  : S_IDLE;
            S_101:   nxt = (b == PATTERN[0]) ? S_1011 : S_10;
            S_1011: begin
                if (b)
                    nxt = S_1;
                else
                    nxt = overlap ? S_10 : S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/detecter_1011_if.sv
// ---------------------------------------------------------------------------
// detecter_1011_if
// Bundles the detector's data-side signals for benches and higher levels.
//   in          : serial bit stream toward the detector
//   out         : one-cycle match flag from the detector
//   match_count : saturating match counter from the detector
// Modports: master drives the stream and observes results; slave is the
// detector side.
// ---------------------------------------------------------------------------
interface detecter_1011_if #(
    parameter int CNT_W = 8
);
    logic             in;
    logic             out;
    logic [CNT_W-1:0] match_count;

    modport master (output in, input out, input match_count);
    modport slave  (input in, output out, output match_count);
endinterface

// File: rtl/detecter_1011_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear
//   inc   : count one event on this edge
//   count : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/detecter_1011.sv
// ---------------------------------------------------------------------------
// detecter_1011
// Moore FSM that flags every occurrence of "1011" in a serial bit stream and
// counts the matches.
//   in          : serial input bit, sampled on each rising clk edge
//   out         : high for one cycle after the final "1" of a match
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   match_count : matches since reset, saturating at all ones
// Parameters: OVERLAP (1 = matches may share bits), CNT_W (counter width).
// ---------------------------------------------------------------------------
module detecter_1011
    import detecter_pkg::*;
#(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             in,
    output logic             out,
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] match_count
);

    state_t state;
    state_t state_nxt;
    logic   enter_match;

    assign state_nxt   = next_state(state, in, OVERLAP != 0);
    assign enter_match = (state_nxt == S_1011);

    // out is a flop loaded with the decode of the state being entered, so it
    // always equals (state == S_1011) and never depends on the live input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            out   <= 1'b0;
        end else begin
            state <= state_nxt;
            out   <= enter_match;
        end
    end

    // S_1011 can never follow itself, so each entry is exactly one match.
    sat_counter #(
        .W(CNT_W)
    ) u_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (enter_match),
        .count(match_count)
    );

endmodule

// File: tb/tb_detecter_1011.sv
// ---------------------------------------------------------------------------
// tb_detecter_1011
// Drives three detector instances (overlapping, non-overlapping, and
// overlapping with a 2-bit counter) from one shared bit stream and compares
// them against a sliding-window reference model.
// ---------------------------------------------------------------------------
module tb_detecter_1011;

    localparam logic [3:0] PAT = 4'b1011;

    logic clk = 1'b0;
    logic rst_n;
    logic in_bit;

    int tests_run = 0;
    int failures  = 0;

    // Reference model: last four bits seen plus how many are valid.
    logic [3:0] hist_ov, hist_nov;
    int         len_ov, len_nov;
    logic       exp_out_ov, exp_out_nov;
    int         cnt_ov, cnt_nov, cnt_sat;

    detecter_1011_if #(.CNT_W(8)) if_ov ();
    detecter_1011_if #(.CNT_W(8)) if_nov ();
    detecter_1011_if #(.CNT_W(2)) if_sat ();

    assign if_ov.in  = in_bit;
    assign if_nov.in = in_bit;
    assign if_sat.in = in_bit;

    detecter_1011 #(.OVERLAP(1), .CNT_W(8)) dut_ov (
        .in(if_ov.in), .out(if_ov.out), .clk(clk), .rst_n(rst_n),
        .match_count(if_ov.match_count)
    );

    detecter_1011 #(.OVERLAP(0), .CNT_W(8)) dut_nov (
        .in(if_nov.in), .out(if_nov.out), .clk(clk), .rst_n(rst_n),
        .match_count(if_nov.match_count)
    );

    detecter_1011 #(.OVERLAP(1), .CNT_W(2)) dut_sat (
        .in(if_sat.in), .out(if_sat.out), .clk(clk), .rst_n(rst_n),
        .match_count(if_sat.match_count)
    );

    always #5 clk = ~clk;

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void model_reset();
        hist_ov     = '0;
        hist_nov    = '0;
        len_ov      = 0;
        len_nov     = 0;
        exp_out_ov  = 1'b0;
        exp_out_nov = 1'b0;
        cnt_ov      = 0;
        cnt_nov     = 0;
        cnt_sat     = 0;
    endfunction

    // A match is "the last four bits are 1011". Non-overlapping mode forgets
    // all history once a match has been reported.
    function automatic void model_edge(input logic b);
        hist_ov = {hist_ov[2:0], b};
        if (len_ov < 4) len_ov++;
        exp_out_ov = (len_ov == 4) && (hist_ov == PAT);
        if (exp_out_ov) begin
            cnt_ov  = (cnt_ov  < 255) ? cnt_ov + 1  : 255;
            cnt_sat = (cnt_sat < 3)   ? cnt_sat + 1 : 3;
        end

        hist_nov = {hist_nov[2:0], b};
        if (len_nov < 4) len_nov++;
        exp_out_nov = (len_nov == 4) && (hist_nov == PAT);
        if (exp_out_nov) begin
            cnt_nov = (cnt_nov < 255) ? cnt_nov + 1 : 255;
            len_nov = 0;
        end
    endfunction

    // Present one bit at the falling edge, let the rising edge sample it,
    // then settle just after the edge for checking.
    task automatic drive_bit(input logic b);
        @(negedge clk);
        in_bit = b;
        @(posedge clk);
        model_edge(b);
        #1;
    endtask

    // Reset asserted and released between clock edges, spanning one edge.
    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        in_bit = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        tests_run++;
        if (if_ov.out !== 1'b0 || if_ov.match_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_ov: got out=%b count=%0d required out=0 count=0", if_ov.out, if_ov.match_count);
        end
        tests_run++;
        if (if_nov.out !== 1'b0 || if_nov.match_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_nov: got out=%b count=%0d required out=0 count=0", if_nov.out, if_nov.match_count);
        end
        tests_run++;
        if (if_sat.out !== 1'b0 || if_sat.match_count !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_sat: got out=%b count=%0d required out=0 count=0", if_sat.out, if_sat.match_count);
        end
    endtask

    task automatic test_directed_seq();
        int   seq [14] = '{1,0,1,0,1,1,1,1,0,1,1,0,1,1};
        logic want_ov, want_nov;
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            drive_bit(seq[i][0]);
            want_ov  = (i + 1 == 6) || (i + 1 == 11) || (i + 1 == 14);
            want_nov = (i + 1 == 6) || (i + 1 == 11);
            tests_run++;
            if (if_ov.out !== want_ov) begin
                failures++;
                $display("[TB] FAIL seq_out_ov bit %0d: got %b required %b", i + 1, if_ov.out, want_ov);
            end
            tests_run++;
            if (if_nov.out !== want_nov) begin
                failures++;
                $display("[TB] FAIL seq_out_nov bit %0d: got %b required %b", i + 1, if_nov.out, want_nov);
            end
        end
        tests_run++;
        if (if_ov.match_count !== 8'd3) begin
            failures++;
            $display("[TB] FAIL seq_count_ov: got %0d required 3", if_ov.match_count);
        end
        tests_run++;
        if (if_nov.match_count !== 8'd2) begin
            failures++;
            $display("[TB] FAIL seq_count_nov: got %0d required 2", if_nov.match_count);
        end
    endtask

    task automatic test_back_to_back();
        int   seq [7] = '{1,0,1,1,0,1,1};
        logic want;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive_bit(seq[i][0]);
            want = (i + 1 == 4) || (i + 1 == 7);
            tests_run++;
            if (if_ov.out !== want) begin
                failures++;
                $display("[TB] FAIL b2b_out bit %0d: got %b required %b", i + 1, if_ov.out, want);
            end
        end
        tests_run++;
        if (if_ov.match_count !== 8'd2) begin
            failures++;
            $display("[TB] FAIL b2b_count: got %0d required 2", if_ov.match_count);
        end
    endtask

    task automatic test_async_reset();
        int pre [4] = '{1,0,1,1};
        apply_reset();
        for (int i = 0; i < 4; i++) drive_bit(pre[i][0]);
        tests_run++;
        if (if_ov.out !== 1'b1 || if_ov.match_count !== 8'd1) begin
            failures++;
            $display("[TB] FAIL async_premise: got out=%b count=%0d required out=1 count=1", if_ov.out, if_ov.match_count);
        end
        // Reset while the match flag is high, away from any clock edge.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (if_ov.out !== 1'b0 || if_ov.match_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL async_in_match: got out=%b count=%0d required out=0 count=0", if_ov.out, if_ov.match_count);
        end
        tests_run++;
        if (if_nov.out !== 1'b0 || if_nov.match_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL async_in_match_nov: got out=%b count=%0d required out=0 count=0", if_nov.out, if_nov.match_count);
        end
        // Input toggling during reset must be ignored across a clock edge.
        @(negedge clk);
        in_bit = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (if_ov.out !== 1'b0 || if_ov.match_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL async_hold: got out=%b count=%0d required out=0 count=0", if_ov.out, if_ov.match_count);
        end
        #1;
        rst_n = 1'b1;
        // Reach S_101, then reset mid-cycle; a following "1" must not match.
        for (int i = 0; i < 3; i++) drive_bit(pre[i][0]);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (if_ov.out !== 1'b0 || if_ov.match_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL async_in_101: got out=%b count=%0d required out=0 count=0", if_ov.out, if_ov.match_count);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive_bit(1'b1);
        tests_run++;
        if (if_ov.out !== 1'b0 || if_nov.out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_discard: got ov=%b nov=%b required 0 0", if_ov.out, if_nov.out);
        end
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        tests_run++;
        if (if_ov.out !== 1'b1 || if_ov.match_count !== 8'd1) begin
            failures++;
            $display("[TB] FAIL async_fresh_match: got out=%b count=%0d required out=1 count=1", if_ov.out, if_ov.match_count);
        end
    endtask

    task automatic test_saturation();
        int pat [4] = '{1,0,1,1};
        apply_reset();
        for (int m = 1; m <= 5; m++) begin
            for (int i = 0; i < 4; i++) drive_bit(pat[i][0]);
            tests_run++;
            if (if_sat.match_count !== 2'(cnt_sat) || if_sat.out !== 1'b1) begin
                failures++;
                $display("[TB] FAIL sat_step match %0d: got out=%b count=%0d required out=1 count=%0d", m, if_sat.out, if_sat.match_count, cnt_sat);
            end
        end
        tests_run++;
        if (if_sat.match_count !== 2'd3) begin
            failures++;
            $display("[TB] FAIL sat_hold: got %0d required 3", if_sat.match_count);
        end
        tests_run++;
        if (if_ov.match_count !== 8'd5 || if_nov.match_count !== 8'd5) begin
            failures++;
            $display("[TB] FAIL sat_wide_counts: got ov=%0d nov=%0d required 5 5", if_ov.match_count, if_nov.match_count);
        end
    endtask

    task automatic test_constant_input();
        for (int v = 1; v >= 0; v--) begin
            apply_reset();
            for (int i = 0; i < 20; i++) begin
                drive_bit(v[0]);
                tests_run++;
                if (if_ov.out !== 1'b0 || if_nov.out !== 1'b0 || if_sat.out !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL const_%0d cycle %0d: got ov=%b nov=%b sat=%b required 0", v, i, if_ov.out, if_nov.out, if_sat.out);
                end
            end
            tests_run++;
            if (if_ov.match_count !== 8'd0) begin
                failures++;
                $display("[TB] FAIL const_%0d_count: got %0d required 0", v, if_ov.match_count);
            end
        end
    endtask

    task automatic test_random();
        logic b;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) apply_reset();
            b = ($urandom_range(0, 99) < 60);
            drive_bit(b);
            tests_run++;
            if (if_ov.out !== exp_out_ov || if_ov.match_count !== 8'(cnt_ov)) begin
                failures++;
                $display("[TB] FAIL rand_ov cycle %0d: got out=%b count=%0d required out=%b count=%0d", i, if_ov.out, if_ov.match_count, exp_out_ov, cnt_ov);
            end
            tests_run++;
            if (if_nov.out !== exp_out_nov || if_nov.match_count !== 8'(cnt_nov)) begin
                failures++;
                $display("[TB] FAIL rand_nov cycle %0d: got out=%b count=%0d required out=%b count=%0d", i, if_nov.out, if_nov.match_count, exp_out_nov, cnt_nov);
            end
            tests_run++;
            if (if_sat.out !== exp_out_ov || if_sat.match_count !== 2'(cnt_sat)) begin
                failures++;
                $display("[TB] FAIL rand_sat cycle %0d: got out=%b count=%0d required out=%b count=%0d", i, if_sat.out, if_sat.match_count, exp_out_ov, cnt_sat);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        in_bit = 1'b0;
        model_reset();
        test_reset();
        test_directed_seq();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        test_constant_input();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
